// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Summary  : Shared AES types, constants and the GF(2^8) doubling helper.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_key_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_SUB  = 2'd1,
        KS_MIX  = 2'd2
    } ks_state_e;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Summary  : 8-bit combinational AES forward S-box (table lookup).
// Revision : 1.0
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    // Entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_data = c_SBOX[11'd2047 - {i_data, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule
// Summary  : Iterative AES-128 round-key generator, byte-serial through one
//            shared S-box. AES_KS_STORE_EN adds an 11-entry key store.
// Revision : 1.0
// ============================================================================
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] cipher_key,
    input  logic         next_req,
`ifdef AES_KS_STORE_EN
    input  logic         key_restart,
`endif
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         err
);
    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    ks_state_e  state_q, state_d;
    logic [1:0] idx_q, idx_d;
    aes_word_t  temp_q, temp_d;
    logic [7:0] rcon_q, rcon_d;
    aes_key_t   round_key_q, round_key_d;
    logic [3:0] rk_round_q, rk_round_d;
    logic       rk_valid_q, rk_valid_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       err_pend_q, err_pend_d;

    aes_word_t  w_rot;
    aes_word_t  w_temp_sub;
    aes_word_t  w_acc;
    aes_key_t   w_mixed;
    logic [7:0] w_sbox_in;
    logic [7:0] w_sbox_out;
    logic [3:0] w_next_round;
    logic       w_last_round;

`ifdef AES_KS_STORE_EN
    aes_key_t   store_q [NR+1];
    logic [NR:0] valid_q, valid_d;
    logic       w_store_we;
    logic [3:0] w_store_idx;
    aes_key_t   w_store_data;
`endif

    assign w_rot        = {round_key_q[23:0], round_key_q[31:24]};
    assign w_next_round = rk_round_q + 4'd1;
    assign w_last_round = (rk_round_q == c_LAST_ROUND);

    always_comb begin
        w_sbox_in = w_rot[31:24];
        case (idx_q)
            2'd0:    w_sbox_in = w_rot[31:24];
            2'd1:    w_sbox_in = w_rot[23:16];
            2'd2:    w_sbox_in = w_rot[15:8];
            default: w_sbox_in = w_rot[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    // Temp word with the current byte already substituted in place.
    always_comb begin
        w_temp_sub = temp_q;
        case (idx_q)
            2'd0:    w_temp_sub[31:24] = w_sbox_out;
            2'd1:    w_temp_sub[23:16] = w_sbox_out;
            2'd2:    w_temp_sub[15:8]  = w_sbox_out;
            default: w_temp_sub[7:0]   = w_sbox_out;
        endcase
    end

    always_comb begin
        w_acc   = w_temp_sub ^ {rcon_q, 24'h0};
        w_mixed = '0;
        for (int i = 0; i < NK; i++) begin
            w_acc = w_acc ^ round_key_q[127-32*i -: 32];
            w_mixed[127-32*i -: 32] = w_acc;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        temp_d      = temp_q;
        rcon_d      = rcon_q;
        round_key_d = round_key_q;
        rk_round_d  = rk_round_q;
        rk_valid_d  = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        err_pend_d  = 1'b0;
`ifdef AES_KS_STORE_EN
        valid_d      = valid_q;
        w_store_we   = 1'b0;
        w_store_idx  = w_next_round;
        w_store_data = w_mixed;
`endif
        if (key_load) begin
            state_d     = KS_IDLE;
            idx_d       = 2'd0;
            round_key_d = cipher_key;
            rk_round_d  = 4'd0;
            rcon_d      = RCON_INIT;
            rk_valid_d  = 1'b1;
            busy_d      = 1'b0;
`ifdef AES_KS_STORE_EN
            valid_d      = '0;
            valid_d[0]   = 1'b1;
            w_store_we   = 1'b1;
            w_store_idx  = 4'd0;
            w_store_data = cipher_key;
`endif
        end
`ifdef AES_KS_STORE_EN
        else if (key_restart) begin
            state_d     = KS_IDLE;
            idx_d       = 2'd0;
            round_key_d = store_q[0];
            rk_round_d  = 4'd0;
            rcon_d      = RCON_INIT;
            rk_valid_d  = 1'b1;
            busy_d      = 1'b0;
        end
`endif
        else begin
            err_d = err_pend_q;
            case (state_q)
                KS_IDLE: begin
                    if (next_req) begin
                        if (w_last_round) begin
                            err_d = 1'b1;
                        end
`ifdef AES_KS_STORE_EN
                        else if (valid_q[w_next_round]) begin
                            round_key_d = store_q[w_next_round];
                            rk_round_d  = w_next_round;
                            rcon_d      = xtime(rcon_q);
                            rk_valid_d  = 1'b1;
                        end
`endif
                        else begin
                            state_d = KS_SUB;
                            idx_d   = 2'd0;
                            busy_d  = 1'b1;
                        end
                    end
                end
                KS_SUB: begin
                    temp_d = w_temp_sub;
                    idx_d  = idx_q + 2'd1;
                    err_d  = err_d | next_req;
                    // Key is committed as the last byte leaves the S-box; MIX presents it.
                    if (idx_q == 2'd3) begin
                        state_d     = KS_MIX;
                        round_key_d = w_mixed;
                        rk_round_d  = w_next_round;
                        rcon_d      = xtime(rcon_q);
                        rk_valid_d  = 1'b1;
`ifdef AES_KS_STORE_EN
                        valid_d[w_next_round] = 1'b1;
                        w_store_we            = 1'b1;
`endif
                    end
                end
                KS_MIX: begin
                    state_d = KS_IDLE;
                    busy_d  = 1'b0;
                    err_d   = err_d | next_req;
                end
                default: begin
                    state_d = KS_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
            // An error that would land on the rk_valid cycle slips one cycle.
            if (err_d && rk_valid_d) begin
                err_pend_d = 1'b1;
                err_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= KS_IDLE;
            idx_q       <= 2'd0;
            temp_q      <= '0;
            rcon_q      <= RCON_INIT;
            round_key_q <= '0;
            rk_round_q  <= 4'd0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            temp_q      <= temp_d;
            rcon_q      <= rcon_d;
            round_key_q <= round_key_d;
            rk_round_q  <= rk_round_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
        end
    end

`ifdef AES_KS_STORE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_store_we) begin
            store_q[w_store_idx] <= w_store_data;
        end
    end
`endif

    assign round_key = round_key_q;
    assign rk_valid  = rk_valid_q;
    assign rk_round  = rk_round_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
`default_nettype wire
